// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encodings and sizing constants for the fetch controller
// Purpose: FSM state type, default timeout and instruction counter width used by
//          fetch_ctrl and fetch_timer.
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [2:0] {
    FSM_FC_IDLE     = 3'd0,
    FSM_FC_MEM_WAIT = 3'd1,
    FSM_FC_IR_WR    = 3'd2,
    FSM_FC_IR_WAIT  = 3'd3,
    FSM_FC_DONE     = 3'd4,
    FSM_FC_ERR      = 3'd5
  } fc_state_t;

  // Default wait budget for mem_ack / ir_wr_ack; legal range 2..255.
  localparam int PA_TIMEOUT_DEF = 16;

  // Width of the completed-fetch counter.
  localparam int INST_CNT_W = 16;

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - 8-bit wait-cycle counter with clear, enable and expired flag
// Purpose: counts cycles spent waiting for an acknowledge.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous clear to 0 (wins over en)
//   en       in   count enable
//   expired  out  high while the count equals PA_TIMEOUT-1
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int PA_TIMEOUT = PA_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(PA_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // Count is registered, so expired is glitch-free for the FSM.
  assign expired = (count == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single instruction fetch sequencer: memory read, IR write, completion
// Purpose: reads one word at the requested PC, writes it into the instruction register
//          over the ir_wr / ir_wr_ack handshake and reports completion or timeout.
// Ports:
//   clk, rst    in   clock, asynchronous active-high reset
//   fetch_req   in   start fetch (sampled in IDLE), pc_in fetch address
//   err_clr     in   leave the error state
//   mem_rd      out  read request level, mem_addr latched address
//   mem_rdata   in   read data, valid with mem_ack pulse
//   ir_data     out  word to IR, ir_wr one-cycle write strobe, ir_wr_ack in acknowledge
//   fetch_busy  out  high outside IDLE, fetch_done one-cycle completion pulse
//   fetch_err   out  timeout flag, inst_cnt completed fetch count (wrapping)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PA_DATA_WIDTH = 32,
  parameter int PA_ADDR_WIDTH = 32,
  parameter int PA_TIMEOUT    = PA_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [PA_ADDR_WIDTH-1:0] pc_in,
  input  logic                     err_clr,
  output logic                     mem_rd,
  output logic [PA_ADDR_WIDTH-1:0] mem_addr,
  input  logic [PA_DATA_WIDTH-1:0] mem_rdata,
  input  logic                     mem_ack,
  output logic [PA_DATA_WIDTH-1:0] ir_data,
  output logic                     ir_wr,
  input  logic                     ir_wr_ack,
  output logic                     fetch_busy,
  output logic                     fetch_done,
  output logic                     fetch_err,
  output logic [INST_CNT_W-1:0]    inst_cnt
);

  fc_state_t state;
  fc_state_t next_state;
  logic      tmr_clr;
  logic      tmr_en;
  logic      tmr_expired;

  fetch_timer #(
    .PA_TIMEOUT(PA_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FSM_FC_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Acks are checked before the timer so an ack in the expiry cycle wins.
  always_comb begin
    next_state = state;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      FSM_FC_IDLE: begin
        tmr_clr = 1'b1;
        if (fetch_req) next_state = FSM_FC_MEM_WAIT;
      end
      FSM_FC_MEM_WAIT: begin
        tmr_en = 1'b1;
        if (mem_ack)          next_state = FSM_FC_IR_WR;
        else if (tmr_expired) next_state = FSM_FC_ERR;
      end
      FSM_FC_IR_WR: begin
        tmr_clr    = 1'b1;
        next_state = FSM_FC_IR_WAIT;
      end
      FSM_FC_IR_WAIT: begin
        tmr_en = 1'b1;
        if (ir_wr_ack)        next_state = FSM_FC_DONE;
        else if (tmr_expired) next_state = FSM_FC_ERR;
      end
      FSM_FC_DONE: begin
        next_state = FSM_FC_IDLE;
      end
      FSM_FC_ERR: begin
        if (err_clr) next_state = FSM_FC_IDLE;
      end
      default: begin
        next_state = FSM_FC_IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so each one is valid in the same
  // cycle the FSM occupies the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      ir_data    <= '0;
      ir_wr      <= 1'b0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      inst_cnt   <= '0;
    end else begin
      mem_rd     <= (next_state == FSM_FC_MEM_WAIT);
      ir_wr      <= (next_state == FSM_FC_IR_WR);
      fetch_busy <= (next_state != FSM_FC_IDLE);
      fetch_done <= (next_state == FSM_FC_DONE);
      fetch_err  <= (next_state == FSM_FC_ERR);
      if (state == FSM_FC_IDLE && fetch_req) begin
        mem_addr <= pc_in;
      end
      if (state == FSM_FC_MEM_WAIT && mem_ack) begin
        ir_data <= mem_rdata;
      end
      if (state == FSM_FC_IR_WAIT && next_state == FSM_FC_DONE) begin
        inst_cnt <= inst_cnt + 1'b1;
      end
    end
  end

endmodule
